// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning HI/LO
//
// Purpose: 32-iteration shift-add multiply and restoring divide for the EX
// stage. Operands are converted to magnitudes at launch. A final FIX cycle
// applies the sign correction and writes HI/LO. MTHI/MTLO writes are
// accepted only while idle.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   start, op       launch request (sampled in IDLE); 00 MULT 01 MULTU 10 DIV 11 DIVU
//   src_a, src_b    multiplicand/dividend, multiplier/divisor
//   cancel          flush: return to IDLE without touching HI/LO
//   hi_we, lo_we    MTHI / MTLO enables, data on wdata
//   busy, done      registered in-flight flag and one-cycle completion pulse
//   hi, lo          architectural HI/LO registers

module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;   // product / quotient must be negated
    logic               neg_rem_q, neg_rem_d;   // remainder follows dividend sign
    logic               dz_q, dz_d;             // divide by zero
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;       // unmodified dividend for divide-by-zero HI
    logic [WIDTH-1:0]   opnd_q, opnd_d;         // multiplicand (mul) or divisor (div) magnitude
    // mul: {partial product, remaining multiplier bits}
    // div: low half holds dividend bits shifting out / quotient bits shifting in
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Launch-time operand conditioning
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    // Iteration datapath
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ok;

    // Fixup datapath
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        a_neg = ~op[0] & src_a[WIDTH-1];
        b_neg = ~op[0] & src_b[WIDTH-1];
        a_mag = a_neg ? (~src_a + 1'b1) : src_a;
        b_mag = b_neg ? (~src_b + 1'b1) : src_b;
    end

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {rem_q, acc_q[WIDTH-1]};
        // The shifted remainder is always below 2*divisor, so a set top bit
        // of the difference means the trial subtraction went negative.
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ok    = ~div_diff[WIDTH];
        prod_fix  = neg_res_q ? (~acc_q + 1'b1) : acc_q;
        quo_fix   = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        rem_fix   = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        a_raw_d   = a_raw_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cancel) begin
                    // Flushed cycle: neither a launch nor a move-to is honoured.
                    state_d = S_IDLE;
                end else if (start) begin
                    state_d   = S_CALC;
                    cnt_d     = '0;
                    is_div_d  = op[1];
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    dz_d      = op[1] & (src_b == '0);
                    a_raw_d   = src_a;
                    rem_d     = '0;
                    if (op[1]) begin
                        opnd_d = b_mag;
                        acc_d  = {{WIDTH{1'b0}}, a_mag};
                    end else begin
                        opnd_d = a_mag;
                        acc_d  = {{WIDTH{1'b0}}, b_mag};
                    end
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end

            S_CALC: begin
                if (is_div_q) begin
                    rem_d = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ok};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (dz_q) begin
                    hi_d = a_raw_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A flush abandons whatever is in flight, including a pending FIX write.
        if (cancel && state_q != S_IDLE) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            a_raw_q   <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            a_raw_q   <= a_raw_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
